// File: rtl/axi_read_mux.sv
// axi_read_mux: locks the read arbiter's grant for one complete AXI read
// transaction (one AR handshake, then R beats through the RLAST handshake).
// While locked, the granted master's AR channel goes to the slave port and
// the slave's R channel comes back to that master.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   arb_valid, arb_sel  grant from the arbiter (only looked at in IDLE)
//   busy, grant_sel     lock status and the latched master index
//   len_err             one-cycle pulse when RLAST disagrees with ARLEN
//   m0_*/m1_*           master-side AR (in) and R (out) channels
//   s_*                 slave-side AR (out) and R (in) channels
module axi_read_mux #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arb_valid,
  input  logic                  arb_sel,
  output logic                  busy,
  output logic                  grant_sel,
  output logic                  len_err,
  // master 0
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [ID_WIDTH-1:0]   m0_arid,
  input  logic [LEN_WIDTH-1:0]  m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [ID_WIDTH-1:0]   m0_rid,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [ID_WIDTH-1:0]   m1_arid,
  input  logic [LEN_WIDTH-1:0]  m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ID_WIDTH-1:0]   m1_rid,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  // slave
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [ID_WIDTH-1:0]   s_arid,
  output logic [LEN_WIDTH-1:0]  s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 sel_arvalid;
  logic                 sel_rready;
  logic                 in_addr, in_data;
  logic                 r_hs;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign busy    = (state != IDLE);

  // AR payload follows the latched master with zero latency; outputs depend
  // only on state/grant_sel, never on arb_*, so there is no arbiter loop.
  always_comb begin
    if (grant_sel) begin
      s_araddr    = m1_araddr;
      s_arid      = m1_arid;
      s_arlen     = m1_arlen;
      s_arsize    = m1_arsize;
      s_arburst   = m1_arburst;
      sel_arvalid = m1_arvalid;
      sel_rready  = m1_rready;
    end else begin
      s_araddr    = m0_araddr;
      s_arid      = m0_arid;
      s_arlen     = m0_arlen;
      s_arsize    = m0_arsize;
      s_arburst   = m0_arburst;
      sel_arvalid = m0_arvalid;
      sel_rready  = m0_rready;
    end
  end

  assign s_arvalid  = in_addr & sel_arvalid;
  assign m0_arready = in_addr & ~grant_sel & s_arready;
  assign m1_arready = in_addr &  grant_sel & s_arready;

  // R payload is broadcast; only the granted master sees rvalid.
  assign m0_rdata  = s_rdata;
  assign m0_rid    = s_rid;
  assign m0_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rdata  = s_rdata;
  assign m1_rid    = s_rid;
  assign m1_rresp  = s_rresp;
  assign m1_rlast  = s_rlast;
  assign m0_rvalid = in_data & ~grant_sel & s_rvalid;
  assign m1_rvalid = in_data &  grant_sel & s_rvalid;
  assign s_rready  = in_data & sel_rready;

  assign r_hs = s_rvalid & s_rready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_sel <= 1'b0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: if (arb_valid) begin
          grant_sel <= arb_sel;
          state     <= ADDR;
        end
        ADDR: begin
          // A withdrawn request releases the grant without issuing an AR.
          if (!sel_arvalid) state <= IDLE;
          else if (s_arready) begin
            beat_cnt <= s_arlen;
            state    <= DATA;
          end
        end
        DATA: if (r_hs) begin
          if (s_rlast) begin
            state   <= IDLE;
            len_err <= (beat_cnt != '0);
          end else if (beat_cnt == '0) begin
            len_err <= 1'b1;  // extra beats: counter parks at zero
          end else begin
            beat_cnt <= beat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_mux.sv
// Bench for axi_read_mux: a procedural slave drives R beats, each beat's
// expected {master, data, last} is queued when driven and popped when the
// granted master sees the handshake.
module tb_axi_read_mux;

  logic        clk = 0, reset = 1;
  logic        arb_valid = 0, arb_sel = 0;
  logic        busy, grant_sel, len_err;
  logic [31:0] m0_araddr = 0, m1_araddr = 0;
  logic [3:0]  m0_arid = 0, m1_arid = 0;
  logic [7:0]  m0_arlen = 0, m1_arlen = 0;
  logic [2:0]  m0_arsize = 3'd2, m1_arsize = 3'd2;
  logic [1:0]  m0_arburst = 2'd1, m1_arburst = 2'd1;
  logic        m0_arvalid = 0, m1_arvalid = 0, m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  m0_rid, m1_rid;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic        m0_rready = 1, m1_rready = 1;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid, s_arready = 0;
  logic [31:0] s_rdata = 0;
  logic [3:0]  s_rid = 0;
  logic [1:0]  s_rresp = 0;
  logic        s_rlast = 0, s_rvalid = 0, s_rready;

  typedef struct { bit sel; logic [31:0] data; logic last; } beat_t;
  beat_t sb[$];

  int checks = 0, errors = 0, err_pulses = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (len_err) err_pulses++;

  axi_read_mux dut (
    .clk(clk), .reset(reset), .arb_valid(arb_valid), .arb_sel(arb_sel),
    .busy(busy), .grant_sel(grant_sel), .len_err(len_err),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rid(m0_rid),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rid(m1_rid),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Both masters request; the ungranted one carries a different payload so
  // a wrong select shows up on s_araddr/s_arlen.
  task automatic set_ar(input bit sel, input logic [31:0] addr, input logic [7:0] len);
    m0_arvalid = 1; m1_arvalid = 1;
    m0_araddr = sel ? ~addr : addr;  m1_araddr = sel ? addr : ~addr;
    m0_arlen  = sel ? ~len  : len;   m1_arlen  = sel ? len  : ~len;
    m0_arid   = sel ? 4'h5 : 4'hA;   m1_arid   = sel ? 4'hA : 4'h5;
  endtask

  task automatic txn(input bit sel, input logic [31:0] addr, input logic [7:0] len,
                     input int nbeats, input int ar_stall, input int gap_beat,
                     input int abort_beat, input int exp_err);
    int    base;
    beat_t e;
    logic  sel_rv, oth_rv;
    arb_valid = 1; arb_sel = sel;
    set_ar(sel, addr, len);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_sarvalid", s_arvalid, 0);
    step();
    arb_valid = 0; arb_sel = ~sel;
    for (int i = 0; i < ar_stall; i++) begin
      s_arready = 0;
      @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_grant", grant_sel, sel);
      chk("stall_sarvalid", s_arvalid, 1);
      chk("stall_araddr", s_araddr, addr);
      chk("stall_arready", {m0_arready, m1_arready}, 0);
      step();
    end
    s_arready = 1;
    @(negedge clk);
    chk("ar_sarvalid", s_arvalid, 1);
    chk("ar_araddr", s_araddr, addr);
    chk("ar_arlen", s_arlen, len);
    chk("ar_arid", s_arid, 4'hA);
    chk("ar_arready", {m1_arready, m0_arready}, sel ? 2'b10 : 2'b01);
    step();
    s_arready = 0; m0_arvalid = 0; m1_arvalid = 0;
    arb_valid = 1; arb_sel = ~sel;  // must be ignored during DATA
    base = err_pulses;
    for (int b = 0; b < nbeats; b++) begin
      s_rvalid = 1; s_rdata = $urandom; s_rid = 4'hA; s_rlast = (b == nbeats - 1);
      if (b == abort_beat) begin
        reset = 1; #1;
        chk("rst_busy", busy, 0);
        chk("rst_srready", s_rready, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_grant", grant_sel, 0);
        @(negedge clk);
        reset = 0; s_rvalid = 0; s_rlast = 0; arb_valid = 0;
        sb.delete();
        step();
        return;
      end
      if (b == gap_beat) begin
        if (sel) m1_rready = 0; else m0_rready = 0;
        repeat (2) begin
          @(negedge clk);
          chk("gap_srready", s_rready, 0);
          chk("gap_rvalid", {m1_rvalid, m0_rvalid}, sel ? 2'b10 : 2'b01);
          step();
        end
        m0_rready = 1; m1_rready = 1;
      end
      sb.push_back('{sel, s_rdata, s_rlast});
      @(negedge clk);
      sel_rv = sel ? m1_rvalid : m0_rvalid;
      oth_rv = sel ? m0_rvalid : m1_rvalid;
      chk("r_other_rvalid", oth_rv, 0);
      chk("r_grant", grant_sel, sel);
      chk("r_handshake", {sel_rv, s_rready}, 2'b11);
      if (sel_rv && s_rready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("r_data", sel ? m1_rdata : m0_rdata, e.data);
        chk("r_last", sel ? m1_rlast : m0_rlast, e.last);
        chk("r_route", sel, e.sel);
      end
      step();
    end
    s_rvalid = 0; s_rlast = 0; arb_valid = 0;
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_srready", s_rready, 0);
    chk("sb_empty", sb.size(), 0);
    step();
    chk("len_err_pulses", err_pulses - base, exp_err);
  endtask

  initial begin
    #1;
    chk("rst_busy0", busy, 0);
    chk("rst_valids", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
    chk("rst_lenerr", len_err, 0);
    @(negedge clk); reset = 0;
    step();
    // sel addr len nbeats stall gap abort exp_err
    txn(0, 32'h1000, 8'd3, 4, 0, -1, -1, 0);  // basic 4-beat burst to m0
    txn(1, 32'h2000, 8'd3, 4, 0, -1, -1, 0);  // m1, arb_sel toggles in DATA
    txn(1, 32'h3000, 8'd1, 2, 5, -1, -1, 0);  // AR stalled 5 cycles
    txn(0, 32'h4000, 8'd2, 2, 0, -1, -1, 1);  // early rlast
    txn(1, 32'h5000, 8'd1, 3, 0, -1, -1, 1);  // too many beats
    txn(0, 32'h6000, 8'd3, 4, 0,  2, -1, 0);  // rready gap mid-burst
    txn(0, 32'h7000, 8'd3, 4, 0, -1,  2, 0);  // reset at beat 2
    txn(1, 32'h8000, 8'd0, 1, 1, -1, -1, 0);  // clean start after reset
    // Withdrawn request: ADDR then back to IDLE with no AR issued.
    arb_valid = 1; arb_sel = 1; m0_arvalid = 0; m1_arvalid = 0;
    step();
    arb_valid = 0;
    @(negedge clk);
    chk("wd_busy", busy, 1);
    chk("wd_sarvalid", s_arvalid, 0);
    step();
    @(negedge clk);
    chk("wd_idle", busy, 0);
    chk("wd_grant_hold", grant_sel, 1);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
